// File: rtl/axis_packetizer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_packetizer_if : request, payload-in and flit-out bundle of the NI   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface axis_packetizer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int XW         = 2,
   parameter int YW         = 2,
   parameter int LW         = 4
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [XW-1:0]         req_x_i;
   logic [YW-1:0]         req_y_i;
   logic [LW-1:0]         req_len_i;
   logic                  s_tvalid_i;
   logic                  s_tready_o;
   logic [DATA_WIDTH-1:0] s_tdata_i;
   logic                  m_tvalid_o;
   logic                  m_tready_i;
   logic [DATA_WIDTH-1:0] m_tdata_o;
   logic                  m_tlast_o;

   // The packetizer side drives the flit stream toward the router.
   modport master (
      input  req_valid_i, req_x_i, req_y_i, req_len_i,
      input  s_tvalid_i, s_tdata_i, m_tready_i,
      output req_ready_o, s_tready_o, m_tvalid_o, m_tdata_o, m_tlast_o
   );

   modport slave (
      output req_valid_i, req_x_i, req_y_i, req_len_i,
      output s_tvalid_i, s_tdata_i, m_tready_i,
      input  req_ready_o, s_tready_o, m_tvalid_o, m_tdata_o, m_tlast_o
   );
endinterface
`default_nettype wire

// File: rtl/axis_packetizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axis_packetizer : builds header + len payload flits for a NoC local port |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axis_packetizer #(
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int MAX_ROUTERS_X   = 4,
   parameter int MAX_ROUTERS_Y   = 4,
   parameter int ROUTER_X        = 0,
   parameter int ROUTER_Y        = 0,
   parameter int MAX_PAYLOAD     = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   axis_packetizer_if.master  bus,
   output logic               busy_o,
   output logic               err_o
);
   localparam int XW = $clog2(MAX_ROUTERS_X);
   localparam int YW = $clog2(MAX_ROUTERS_Y);
   localparam int LW = $clog2(MAX_PAYLOAD + 1);
   localparam int HW = 2 * (XW + YW) + LW;

   localparam logic [XW:0]   C_MAX_X   = MAX_ROUTERS_X[XW:0];
   localparam logic [YW:0]   C_MAX_Y   = MAX_ROUTERS_Y[YW:0];
   localparam logic [LW-1:0] C_MAX_LEN = MAX_PAYLOAD[LW-1:0];
   localparam logic [LW-1:0] C_ONE     = LW'(1);
   localparam logic [XW-1:0] C_SRC_X   = ROUTER_X[XW-1:0];
   localparam logic [YW-1:0] C_SRC_Y   = ROUTER_Y[YW-1:0];

   generate
      if (AXIS_DATA_WIDTH < HW || MAX_ROUTERS_X < 2 || MAX_ROUTERS_Y < 2) begin : g_param_check
         $error("axis_packetizer: illegal parameterisation (mesh < 2 or header wider than flit)");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HEADER  = 2'd1,
      S_PAYLOAD = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [LW-1:0]              cnt_q, cnt_d;
   logic [LW-1:0]              len_q, len_d;
   logic [XW-1:0]              x_q, x_d;
   logic [YW-1:0]              y_q, y_d;
   logic                       err_q, err_d;
   logic                       req_ok;
   logic [AXIS_DATA_WIDTH-1:0] header;

   always_comb begin
      req_ok = (bus.req_len_i != '0) && (bus.req_len_i <= C_MAX_LEN) &&
               ({1'b0, bus.req_x_i} < C_MAX_X) && ({1'b0, bus.req_y_i} < C_MAX_Y);
   end

   always_comb begin
      header         = '0;
      header[HW-1:0] = {len_q, C_SRC_Y, C_SRC_X, y_q, x_q};
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      len_d           = len_q;
      x_d             = x_q;
      y_d             = y_q;
      err_d           = err_q;
      bus.req_ready_o = 1'b0;
      bus.s_tready_o  = 1'b0;
      bus.m_tvalid_o  = 1'b0;
      bus.m_tdata_o   = '0;
      bus.m_tlast_o   = 1'b0;

      case (state_q)
         S_IDLE: begin
            bus.req_ready_o = ~rst_i;
            if (bus.req_valid_i && !rst_i) begin
               x_d   = bus.req_x_i;
               y_d   = bus.req_y_i;
               len_d = bus.req_len_i;
               if (req_ok) begin
                  cnt_d   = bus.req_len_i;
                  state_d = S_HEADER;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_HEADER: begin
            bus.m_tvalid_o = 1'b1;
            bus.m_tdata_o  = header;
            if (bus.m_tready_i) begin
               state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            // Pure pass-through: the upstream source owns data stability here.
            bus.m_tvalid_o = bus.s_tvalid_i;
            bus.s_tready_o = bus.m_tready_i;
            bus.m_tdata_o  = bus.s_tdata_i;
            bus.m_tlast_o  = (cnt_q == C_ONE);
            if (bus.s_tvalid_i && bus.m_tready_i) begin
               cnt_d = cnt_q - C_ONE;
               if (cnt_q == C_ONE) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         x_q     <= x_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   assign busy_o = (state_q != S_IDLE);
   assign err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_packetizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axis_packetizer : randomized packet streams against a flit-list model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_axis_packetizer;
   localparam int DW  = 32;
   localparam int MRX = 3;
   localparam int MRY = 4;
   localparam int RX  = 1;
   localparam int RY  = 2;
   localparam int MP  = 8;
   localparam int XW  = $clog2(MRX);
   localparam int YW  = $clog2(MRY);
   localparam int LW  = $clog2(MP + 1);
   localparam int BUDGET = 3000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, err;

   axis_packetizer_if #(.DATA_WIDTH(DW), .XW(XW), .YW(YW), .LW(LW)) bus ();

   axis_packetizer #(
      .AXIS_DATA_WIDTH(DW), .MAX_ROUTERS_X(MRX), .MAX_ROUTERS_Y(MRY),
      .ROUTER_X(RX), .ROUTER_Y(RY), .MAX_PAYLOAD(MP)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus),
      .busy_o(busy),
      .err_o (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   // Header as a plain weighted sum of its fields.
   function automatic logic [DW-1:0] hdr(input int x, input int y, input int len);
      return DW'(x + y * (2 ** XW) + RX * (2 ** (XW + YW)) + RY * (2 ** (2 * XW + YW)) +
                 len * (2 ** (2 * XW + 2 * YW)));
   endfunction

   function automatic bit pkt_ok(input int x, input int y, input int len);
      return (len >= 1) && (len <= MP) && (x < MRX) && (y < MRY);
   endfunction

   // Output monitor: captures every flit handshake and checks AXIS hold rules.
   int              cyc = 0;
   logic [DW-1:0]   obs_d[$];
   bit              obs_l[$];
   int              obs_t[$];
   logic            pv = 1'b0;
   logic [DW-1:0]   pd = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.m_tvalid_o && bus.m_tready_i) begin
            obs_d.push_back(bus.m_tdata_o);
            obs_l.push_back(bus.m_tlast_o);
            obs_t.push_back(cyc);
         end
         if (pv) begin
            check("hold_valid", bus.m_tvalid_o, 1);
            check("hold_data", bus.m_tdata_o, pd);
         end
         if (!busy) begin
            check("idle_tvalid", bus.m_tvalid_o, 0);
            check("idle_tdata", bus.m_tdata_o, 0);
         end
         pv <= bus.m_tvalid_o && !bus.m_tready_i;
         pd <= bus.m_tdata_o;
      end else begin
         pv <= 1'b0;
      end
   end

   int            pk_x[$], pk_y[$], pk_len[$];
   logic [DW-1:0] fix_pay[$];
   bit            err_exp = 1'b0;

   task automatic drive_idle();
      bus.req_valid_i = 1'b0;
      bus.req_x_i     = '0;
      bus.req_y_i     = '0;
      bus.req_len_i   = '0;
      bus.s_tvalid_i  = 1'b0;
      bus.s_tdata_i   = '0;
      bus.m_tready_i  = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_req_ready", bus.req_ready_o, 0);
         check("rst_tvalid", bus.m_tvalid_o, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      err_exp = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", bus.req_ready_o, 1);
      check("post_rst_busy", busy, 0);
      check("post_rst_err", err, 0);
      check("post_rst_tvalid", bus.m_tvalid_o, 0);
      check("post_rst_tdata", bus.m_tdata_o, 0);
      check("post_rst_tlast", bus.m_tlast_o, 0);
      check("post_rst_s_tready", bus.s_tready_o, 0);
      @(posedge clk); #1;
   endtask

   // Issues all queued requests back-to-back with a concatenated payload stream.
   task automatic run_stream(input bit bp, input int abort_after);
      logic [DW-1:0] pay[$];
      logic [DW-1:0] exp_d[$];
      bit            exp_l[$], exp_h[$], exp_g[$];
      logic [DW-1:0] w, hdr_e;
      int            ri, si, oc, c, ncmp;
      bit            hdr_due, hr, hs, hm, aborted;

      for (int p = 0; p < pk_x.size(); p++) begin
         if (pkt_ok(pk_x[p], pk_y[p], pk_len[p])) begin
            exp_d.push_back(hdr(pk_x[p], pk_y[p], pk_len[p]));
            exp_l.push_back(1'b0);
            exp_h.push_back(1'b1);
            exp_g.push_back(p > 0 && pkt_ok(pk_x[p-1], pk_y[p-1], pk_len[p-1]));
            for (int i = 0; i < pk_len[p]; i++) begin
               w = (fix_pay.size() > 0) ? fix_pay.pop_front() : DW'($urandom);
               pay.push_back(w);
               exp_d.push_back(w);
               exp_l.push_back(i == pk_len[p] - 1);
               exp_h.push_back(1'b0);
               exp_g.push_back(1'b0);
            end
         end else begin
            err_exp = 1'b1;
         end
      end

      obs_d.delete(); obs_l.delete(); obs_t.delete();
      ri = 0; si = 0; oc = 0; c = 0; hdr_due = 0; hdr_e = '0; aborted = 0;

      while ((ri < pk_x.size() || si < pay.size() || busy) && c < BUDGET) begin
         if (ri < pk_x.size()) begin
            bus.req_valid_i = 1'b1;
            bus.req_x_i     = XW'(pk_x[ri]);
            bus.req_y_i     = YW'(pk_y[ri]);
            bus.req_len_i   = LW'(pk_len[ri]);
         end else begin
            bus.req_valid_i = 1'b0;
         end
         if (si < pay.size()) begin
            if (!bus.s_tvalid_i) bus.s_tvalid_i = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.s_tdata_i = pay[si];
         end else begin
            bus.s_tvalid_i = 1'b0;
         end
         bus.m_tready_i = bp ? ($urandom_range(0, 3) != 0) : 1'b1;

         @(negedge clk);
         if (hdr_due) begin
            check("hdr_latency", bus.m_tvalid_o, 1);
            check("hdr_data", bus.m_tdata_o, hdr_e);
            hdr_due = 0;
         end
         if (oc < exp_d.size() && !exp_h[oc])
            check("s_tready_mirror", bus.s_tready_o, bus.m_tready_i);
         hr = bus.req_valid_i && bus.req_ready_o;
         hs = bus.s_tvalid_i && bus.s_tready_o;
         hm = bus.m_tvalid_o && bus.m_tready_i;
         if (hr && pkt_ok(pk_x[ri], pk_y[ri], pk_len[ri])) begin
            hdr_due = 1;
            hdr_e   = hdr(pk_x[ri], pk_y[ri], pk_len[ri]);
         end

         @(posedge clk); #1;
         if (hr) ri++;
         if (hs) begin
            si++;
            bus.s_tvalid_i = 1'b0;
         end
         if (hm) oc++;
         c++;
         if (abort_after >= 0 && si == abort_after) begin
            aborted = 1;
            break;
         end
      end
      check("cycles_in_budget", c < BUDGET, 1);

      if (aborted) begin
         rst = 1'b1;
         drive_idle();
         @(posedge clk); #1;
         @(negedge clk);
         check("abort_busy", busy, 0);
         check("abort_tvalid", bus.m_tvalid_o, 0);
         check("abort_req_ready", bus.req_ready_o, 0);
         @(posedge clk); #1;
         rst = 1'b0;
         err_exp = 1'b0;
      end
      drive_idle();

      ncmp = aborted ? 1 + abort_after : exp_d.size();
      check("flit_count", obs_d.size(), ncmp);
      for (int i = 0; i < ncmp && i < obs_d.size(); i++) begin
         check("flit_data", obs_d[i], exp_d[i]);
         check("flit_tlast", obs_l[i], exp_l[i]);
         if (!bp && !aborted && i > 0) begin
            if (!exp_h[i]) check("payload_gap", obs_t[i] - obs_t[i-1], 1);
            else if (exp_g[i]) check("b2b_gap", obs_t[i] - obs_t[i-1], 2);
         end
      end
      if (!aborted) check("err_flag", err, err_exp);

      pk_x.delete(); pk_y.delete(); pk_len.delete(); fix_pay.delete();
      @(posedge clk); #1;
   endtask

   task automatic add_pkt(input int x, input int y, input int len);
      pk_x.push_back(x);
      pk_y.push_back(y);
      pk_len.push_back(len);
   endtask

   initial begin
      drive_idle();
      do_reset();

      // Directed single packet, then the same under backpressure.
      for (int b = 0; b < 2; b++) begin
         add_pkt(2, 1, 3);
         fix_pay.push_back(32'hA); fix_pay.push_back(32'hB); fix_pay.push_back(32'hC);
         run_stream(b[0], -1);
      end

      // Invalid requests (zero, oversize, x out of mesh) then a good one.
      add_pkt(1, 1, 0);
      add_pkt(1, 1, 9);
      add_pkt(3, 0, 2);
      add_pkt(0, 3, 2);
      run_stream(1'b0, -1);

      // Back-to-back single-flit packets.
      add_pkt(1, 2, 1);
      add_pkt(2, 3, 1);
      run_stream(1'b0, -1);

      // Randomized streams, some containing invalid requests.
      for (int s = 0; s < 25; s++) begin
         int np;
         np = $urandom_range(1, 4);
         for (int p = 0; p < np; p++) begin
            if ($urandom_range(0, 7) == 0)
               add_pkt($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) * 9);
            else
               add_pkt($urandom_range(0, MRX - 1), $urandom_range(0, MRY - 1), $urandom_range(1, MP));
         end
         run_stream($urandom_range(0, 1) == 1, -1);
      end

      // Reset after the second of four payload flits, then a fresh packet.
      add_pkt(2, 2, 4);
      run_stream(1'b0, 2);
      add_pkt(1, 0, 2);
      run_stream(1'b1, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/axis_packetizer.md
# axis_packetizer

Network-interface injection stage that sits directly upstream of a router's local input channel. It turns a local request (destination coordinates plus payload length) and a payload data stream into one NoC packet: a header flit carrying target/source coordinates and length, then exactly `len` payload flits, with `tlast` on the final flit. The router's arbiter decodes target X/Y from this header.

## Interface
- `AXIS_DATA_WIDTH`, 32: flit width.
- `MAX_ROUTERS_X`, 4: mesh width. Must be ≥2.
- `MAX_ROUTERS_Y`, 4: mesh height. Must be ≥2.
- `ROUTER_X`, 0: this node's X coordinate, written into the header source field.
- `ROUTER_Y`, 0: this node's Y coordinate.
- `MAX_PAYLOAD`, 8: maximum payload flits per packet.
- Derived widths: XW = $clog2(MAX_ROUTERS_X), YW = $clog2(MAX_ROUTERS_Y), LW = $clog2(MAX_PAYLOAD+1).
- Elaboration must fail if AXIS_DATA_WIDTH < 2·(XW+YW)+LW.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request accepted when high together with `req_valid_i`.
- `req_x_i`, in, XW: target X.
- `req_y_i`, in, YW: target Y.
- `req_len_i`, in, LW: payload flit count.
- `s_tvalid_i`, in, 1: payload valid.
- `s_tready_o`, out, 1: payload ready.
- `s_tdata_i`, in, AXIS_DATA_WIDTH: payload data. Upstream tlast is not present and not used.
- `m_tvalid_o`, out, 1: packet flit valid, toward the router input.
- `m_tready_i`, in, 1: router ready.
- `m_tdata_o`, out, AXIS_DATA_WIDTH: flit data.
- `m_tlast_o`, out, 1: last flit of the packet.
- `busy_o`, out, 1: high whenever the FSM is not in IDLE.
- `err_o`, out, 1: sticky flag for a rejected request. Cleared only by reset.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD.
- **IDLE**
  - `req_ready_o`=1. `m_tvalid_o`=0. `s_tready_o`=0.
  - On a request handshake, latch x, y and len. Then:
    - If len==0, len>MAX_PAYLOAD, x≥MAX_ROUTERS_X or y≥MAX_ROUTERS_Y: drop the request, set `err_o`, stay in IDLE. Nothing is emitted.
    - Otherwise go to HEADER and load the down-counter `cnt` with len.
- **HEADER**
  - `m_tvalid_o`=1, `m_tlast_o`=0. `s_tready_o`=0. `req_ready_o`=0.
  - `m_tdata_o` fields, LSB first:
    - [XW-1:0] = target x
    - next YW bits = target y
    - next XW bits = ROUTER_X
    - next YW bits = ROUTER_Y
    - next LW bits = len
    - all remaining bits = 0.
  - On `m_tready_i`, go to PAYLOAD.
- **PAYLOAD** (combinational pass-through, no storage)
  - `m_tvalid_o` = `s_tvalid_i`; `s_tready_o` = `m_tready_i`; `m_tdata_o` = `s_tdata_i`.
  - `m_tlast_o` = (cnt==1).
  - On each beat (`s_tvalid_i` && `m_tready_i`), `cnt` decrements.
  - On the beat with cnt==1, go to IDLE.
- `cnt` arithmetic is LW bits unsigned. It never underflows, because len≥1 is enforced.
- AXI-Stream rules on the output:
  - Once `m_tvalid_o` rises it holds, with stable data, until a handshake. The header is held by the FSM; during payload, stability is the upstream source's obligation.
  - `m_tvalid_o` never depends on `m_tready_i`.
- `m_tdata_o` is 0 whenever `m_tvalid_o`=0 outside PAYLOAD.

## Timing
- Reset values: state=IDLE, cnt=0, latched fields=0, `err_o`=0, `busy_o`=0, `m_tvalid_o`=0, `m_tlast_o`=0, `m_tdata_o`=0, `s_tready_o`=0, `req_ready_o`=1. While `rst_i` is high, `req_ready_o` is forced to 0.
- Request accepted in cycle N → header valid in cycle N+1.
- The first payload flit can transfer in the cycle after the header handshake.
- The payload path has zero added latency.
- Packet overhead is exactly 1 cycle (the header) under no backpressure.
- Back-to-back packets: the last payload beat is in cycle M → `req_ready_o`=1 in cycle M+1 → the next header appears in cycle M+2. At most one bubble cycle.
- A rejected request costs one cycle; the next request can be accepted in the following cycle.
- Reset asserted mid-packet: the FSM returns to IDLE on the next edge. The partial packet is abandoned without `tlast`; the downstream router is reset with it.
- Backpressure in HEADER: the header stays valid and stable indefinitely.

## Test plan
- **Reset:** hold `rst_i` for 3 cycles → all outputs at their reset values, `req_ready_o`=0 during reset and 1 in the first cycle after.
- **Single packet** (XW=YW=2, LW=4, ROUTER=(0,0)), request x=2, y=1, len=3, payload 0xA,0xB,0xC, `m_tready_i`=1 → flits 0x306, 0xA, 0xB, 0xC; `tlast` only on 0xC; header one cycle after the request handshake.
- **Backpressure:** same packet with `m_tready_i` toggling 1,0,0,1 → the header holds stable, no flit is lost or duplicated, `s_tready_o` mirrors `m_tready_i` in PAYLOAD.
- **Invalid requests:** len=0, then len=9 → no `m_tvalid_o`, `err_o`=1 from the cycle after the first and staying 1; a following valid request is still packetized.
- **Back-to-back:** two len=1 packets queued → header1, data1(tlast), idle, header2, data2(tlast); exactly one bubble.
- **Reset mid-payload:** assert reset after the 2nd of 4 flits → IDLE, `m_tvalid_o`=0 next cycle; a new packet afterwards is correct.
